// File: rtl/channel_serializer.sv
// channel_serializer
//
// Drains 140-bit frame records from an upstream FIFO and replays each one as a
// burst of 16-bit words on one of eight channels. Each output word is handed
// over with a valid/ready handshake.
//
// Record layout: [139:12] payload (first word in [139:124]), [11:4] ch_sel,
// [3:0] len. The first len words of the payload are sent and the rest are
// ignored. A record is dropped, with a one-cycle sel_err pulse, when len is
// outside 1..8 or when ch_sel is illegal.
//
// Build option:
//   SER_ONEHOT_CHECK_EN  defined: ch_sel must be one-hot.
//                        undefined: any nonzero ch_sel is accepted, and a
//                        multi-hot ch_sel sends the same words to every
//                        selected channel.
//
// Ports:
//   clk_in          system clock
//   rst_n           asynchronous, active-low reset
//   fifo_empty      upstream FIFO holds no record
//   fifo_r_enable   FIFO read strobe, one cycle per record; data arrives next cycle
//   data_from_fifo  record from the FIFO
//   dout            current output word
//   ch_valid        per-channel valid for dout
//   dout_ready      sink accepts dout this cycle
//   frame_done      one-cycle pulse after the last word of a record transfers
//   sel_err         one-cycle pulse when a record is dropped
//   busy            high whenever the serializer is not idle
module channel_serializer (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         fifo_empty,
  output logic         fifo_r_enable,
  input  logic [139:0] data_from_fifo,
  output logic [15:0]  dout,
  output logic [7:0]   ch_valid,
  input  logic         dout_ready,
  output logic         frame_done,
  output logic         sel_err,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StRd, StCap, StSend} state_e;

  state_e       state_q, state_d;
  logic [127:0] payload_q, payload_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [7:0]   ch_valid_q, ch_valid_d;
  logic         rd_q, rd_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         busy_q, busy_d;

  logic [7:0] in_ch;
  logic [3:0] in_len;
  logic       len_ok, ch_ok;

  assign in_ch  = data_from_fifo[11:4];
  assign in_len = data_from_fifo[3:0];
  assign len_ok = (in_len != 4'd0) && (in_len <= 4'd8);

`ifdef SER_ONEHOT_CHECK_EN
  // Exactly one bit set: nonzero, and clearing the lowest set bit leaves zero.
  assign ch_ok = (in_ch != 8'd0) && ((in_ch & (in_ch - 8'd1)) == 8'd0);
`else
  assign ch_ok = (in_ch != 8'd0);
`endif

  always_comb begin
    state_d    = state_q;
    payload_d  = payload_q;
    cnt_d      = cnt_q;
    ch_valid_d = ch_valid_q;
    rd_d       = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StRd;
          rd_d    = 1'b1;
        end
      end
      StRd: begin
        state_d = StCap;
      end
      StCap: begin
        payload_d = data_from_fifo[139:12];
        cnt_d     = in_len;
        if (len_ok && ch_ok) begin
          ch_valid_d = in_ch;
          state_d    = StSend;
        end else begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StSend: begin
        if (dout_ready) begin
          if (cnt_q == 4'd1) begin
            // Payload is left unshifted so dout keeps showing the last word.
            ch_valid_d = 8'd0;
            done_d     = 1'b1;
            state_d    = StIdle;
          end else begin
            payload_d = {payload_q[111:0], 16'h0000};
            cnt_d     = cnt_q - 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      payload_q  <= '0;
      cnt_q      <= '0;
      ch_valid_q <= '0;
      rd_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      payload_q  <= payload_d;
      cnt_q      <= cnt_d;
      ch_valid_q <= ch_valid_d;
      rd_q       <= rd_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign fifo_r_enable = rd_q;
  assign dout          = payload_q[127:112];
  assign ch_valid      = ch_valid_q;
  assign frame_done    = done_q;
  assign sel_err       = err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_channel_serializer.sv
// Directed testbench for channel_serializer. The bench plays the upstream FIFO
// itself: it holds the record on data_from_fifo while it drives fifo_empty low,
// and raises fifo_empty again once the read strobe has been seen.
module tb_channel_serializer;

  logic         clk_in = 1'b0;
  logic         rst_n;
  logic         fifo_empty;
  logic         fifo_r_enable;
  logic [139:0] data_from_fifo;
  logic [15:0]  dout;
  logic [7:0]   ch_valid;
  logic         dout_ready;
  logic         frame_done;
  logic         sel_err;
  logic         busy;

  int checks = 0;
  int fails  = 0;

  channel_serializer dut (
    .clk_in         (clk_in),
    .rst_n          (rst_n),
    .fifo_empty     (fifo_empty),
    .fifo_r_enable  (fifo_r_enable),
    .data_from_fifo (data_from_fifo),
    .dout           (dout),
    .ch_valid       (ch_valid),
    .dout_ready     (dout_ready),
    .frame_done     (frame_done),
    .sel_err        (sel_err),
    .busy           (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [139:0] mkrec(input logic [127:0] p, input logic [7:0] ch,
                                         input logic [3:0] len);
    return {p, ch, len};
  endfunction

  // Hand over one record. Returns sampled in the cycle after capture, which is
  // the cycle that shows either the first word or the sel_err pulse.
  task automatic start_rec(input string tag, input logic [139:0] rec);
    data_from_fifo = rec;
    fifo_empty     = 1'b0;
    tick();
    chk({tag, "_rden"}, {15'd0, fifo_r_enable}, 16'd1);
    fifo_empty = 1'b1;
    tick();
    chk({tag, "_rden_off"}, {15'd0, fifo_r_enable}, 16'd0);
    chk({tag, "_busy_cap"}, {15'd0, busy}, 16'd1);
    tick();
  endtask

  initial begin
    rst_n          = 1'b0;
    fifo_empty     = 1'b1;
    data_from_fifo = '0;
    dout_ready     = 1'b1;
    #12;
    chk("rst_rden",  {15'd0, fifo_r_enable}, 16'd0);
    chk("rst_chv",   {8'd0, ch_valid}, 16'd0);
    chk("rst_done",  {15'd0, frame_done}, 16'd0);
    chk("rst_err",   {15'd0, sel_err}, 16'd0);
    chk("rst_busy",  {15'd0, busy}, 16'd0);
    chk("rst_dout",  dout, 16'h0000);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_busy", {15'd0, busy}, 16'd0);

    // Single word on channel 2.
    start_rec("t1", mkrec({16'hA5A5, 112'h0}, 8'h04, 4'd1));
    chk("t1_chv",  {8'd0, ch_valid}, 16'h0004);
    chk("t1_dout", dout, 16'hA5A5);
    chk("t1_done_early", {15'd0, frame_done}, 16'd0);
    tick();
    chk("t1_chv_off", {8'd0, ch_valid}, 16'h0000);
    chk("t1_done", {15'd0, frame_done}, 16'd1);
    chk("t1_busy_off", {15'd0, busy}, 16'd0);
    chk("t1_dout_hold", dout, 16'hA5A5);
    tick();
    chk("t1_done_pulse", {15'd0, frame_done}, 16'd0);

    // Full eight-word burst on channel 7.
    start_rec("t2", mkrec({16'h0001, 16'h0002, 16'h0003, 16'h0004,
                           16'h0005, 16'h0006, 16'h0007, 16'h0008}, 8'h80, 4'd8));
    for (int k = 0; k < 8; k++) begin
      chk("t2_dout", dout, 16'(k + 1));
      chk("t2_chv", {8'd0, ch_valid}, 16'h0080);
      chk("t2_rden", {15'd0, fifo_r_enable}, 16'd0);
      tick();
    end
    chk("t2_done", {15'd0, frame_done}, 16'd1);
    chk("t2_chv_off", {8'd0, ch_valid}, 16'h0000);

    // Backpressure while word 2 is presented.
    start_rec("t3", mkrec({16'h1111, 16'h2222, 16'h3333, 16'h4444, 64'h0}, 8'h01, 4'd3));
    chk("t3_w0", dout, 16'h1111);
    tick();
    chk("t3_w1", dout, 16'h2222);
    dout_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold_dout", dout, 16'h2222);
      chk("t3_hold_chv", {8'd0, ch_valid}, 16'h0001);
      chk("t3_hold_done", {15'd0, frame_done}, 16'd0);
    end
    dout_ready = 1'b1;
    tick();
    chk("t3_w2", dout, 16'h3333);
    chk("t3_w2_chv", {8'd0, ch_valid}, 16'h0001);
    tick();
    chk("t3_done", {15'd0, frame_done}, 16'd1);
    chk("t3_chv_off", {8'd0, ch_valid}, 16'h0000);

    // Length out of range in both directions.
    start_rec("t4a", mkrec({16'hDEAD, 112'h0}, 8'h01, 4'd0));
    chk("t4a_err", {15'd0, sel_err}, 16'd1);
    chk("t4a_chv", {8'd0, ch_valid}, 16'h0000);
    chk("t4a_busy", {15'd0, busy}, 16'd0);
    chk("t4a_done", {15'd0, frame_done}, 16'd0);
    tick();
    chk("t4a_err_pulse", {15'd0, sel_err}, 16'd0);
    start_rec("t4b", mkrec({16'hDEAD, 112'h0}, 8'h02, 4'd9));
    chk("t4b_err", {15'd0, sel_err}, 16'd1);
    chk("t4b_chv", {8'd0, ch_valid}, 16'h0000);
    tick();
    chk("t4b_err_pulse", {15'd0, sel_err}, 16'd0);
    chk("t4b_chv2", {8'd0, ch_valid}, 16'h0000);
    start_rec("t4c", mkrec({16'hBEEF, 112'h0}, 8'h02, 4'd1));
    chk("t4c_chv", {8'd0, ch_valid}, 16'h0002);
    chk("t4c_dout", dout, 16'hBEEF);
    chk("t4c_err", {15'd0, sel_err}, 16'd0);
    tick();
    chk("t4c_done", {15'd0, frame_done}, 16'd1);

    // Multi-hot channel select.
    start_rec("t5", mkrec({16'h1234, 16'h5678, 96'h0}, 8'h03, 4'd2));
`ifdef SER_ONEHOT_CHECK_EN
    chk("t5_err", {15'd0, sel_err}, 16'd1);
    chk("t5_chv", {8'd0, ch_valid}, 16'h0000);
    tick();
    chk("t5_chv2", {8'd0, ch_valid}, 16'h0000);
    chk("t5_done", {15'd0, frame_done}, 16'd0);
`else
    chk("t5_err", {15'd0, sel_err}, 16'd0);
    chk("t5_chv", {8'd0, ch_valid}, 16'h0003);
    chk("t5_w0", dout, 16'h1234);
    tick();
    chk("t5_w1", dout, 16'h5678);
    chk("t5_chv2", {8'd0, ch_valid}, 16'h0003);
    tick();
    chk("t5_done", {15'd0, frame_done}, 16'd1);
    chk("t5_chv_off", {8'd0, ch_valid}, 16'h0000);
`endif
    tick();

    // Reset during word 4 of an eight-word burst.
    start_rec("t6", mkrec({16'h0011, 16'h0022, 16'h0033, 16'h0044,
                           16'h0055, 16'h0066, 16'h0077, 16'h0088}, 8'h10, 4'd8));
    tick();
    tick();
    tick();
    chk("t6_w3", dout, 16'h0044);
    chk("t6_chv", {8'd0, ch_valid}, 16'h0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_chv",  {8'd0, ch_valid}, 16'h0000);
    chk("t6_rst_dout", dout, 16'h0000);
    chk("t6_rst_busy", {15'd0, busy}, 16'd0);
    chk("t6_rst_rden", {15'd0, fifo_r_enable}, 16'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_idle_busy", {15'd0, busy}, 16'd0);
      chk("t6_idle_rden", {15'd0, fifo_r_enable}, 16'd0);
      chk("t6_idle_chv", {8'd0, ch_valid}, 16'h0000);
    end
    start_rec("t6n", mkrec({16'hCAFE, 112'h0}, 8'h20, 4'd1));
    chk("t6n_chv", {8'd0, ch_valid}, 16'h0020);
    chk("t6n_dout", dout, 16'hCAFE);
    tick();
    chk("t6n_done", {15'd0, frame_done}, 16'd1);
    chk("t6n_busy", {15'd0, busy}, 16'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/channel_serializer.md
# channel_serializer

Drains 140-bit frame records from the parser's output FIFO and replays each as a burst of 16-bit words on one of eight channel outputs. Sits directly downstream of the frame FIFO; each record carries the payload left-aligned in bits [139:12], the channel select in [11:4] and the word count in [3:0]. Malformed records are dropped and flagged; output words obey a valid/ready handshake.

## Interface
- No parameters.
- clk_in  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- fifo_empty  in  1  FIFO has no record
- fifo_r_enable  out  1  FIFO read strobe, one cycle per record; FIFO returns data on the following cycle
- data_from_fifo  in  140  record: [139:12] payload (first word in [139:124]), [11:4] ch_sel, [3:0] len
- dout  out  16  current output word
- ch_valid  out  8  per-channel valid; at most one bit high (see Configuration)
- dout_ready  in  1  sink accepts dout this cycle
- frame_done  out  1  one-cycle pulse after last word of a record transfers
- sel_err  out  1  one-cycle pulse when a record is dropped
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, RD, CAP, SEND.
- IDLE: if fifo_empty==0, go RD. All outputs registered.
- RD: fifo_r_enable=1 for exactly this cycle; go CAP.
- CAP: latch data_from_fifo into payload shift register (128 b), ch reg (8 b), word_cnt (4 b). Validity check on incoming fields: len in 1..8 and ch_sel legal. Valid -> SEND. Invalid -> pulse sel_err next cycle, no ch_valid, go IDLE.
- ch_sel legal: exactly one bit set (with SER_ONEHOT_CHECK_EN); nonzero (without).
- SEND: dout = payload[127:112]; ch_valid = ch reg. On dout_ready=1: shift payload left 16, word_cnt-=1. When word_cnt==1 and dout_ready=1: drop ch_valid, pulse frame_done, go IDLE.
- dout_ready=0 holds dout and ch_valid stable indefinitely.
- Words per record = len; remaining payload bits ignored. Word k (0-based) = data_from_fifo[139-16k -: 16].
- ch_valid bit i ↔ channel i = ch_sel[i].
- Never reads FIFO while busy; fifo_empty ignored outside IDLE.

## Timing
- Reset: state IDLE; fifo_r_enable, ch_valid, frame_done, sel_err, busy = 0; dout = 16'h0000; internal registers 0.
- fifo_empty low sampled at edge N (IDLE) -> fifo_r_enable high cycle N+1 -> capture at end of N+2 -> first ch_valid cycle N+3.
- Record of len L with dout_ready tied high: ch_valid high L cycles; frame_done high the cycle after last transfer; back in IDLE that same cycle; next fifo_r_enable earliest one cycle later. Per-record overhead 3 idle cycles.
- sel_err asserts cycle N+3 instead of ch_valid; busy low that cycle.
- frame_done and sel_err never high together.
- dout after final word: holds last value; not meaningful while ch_valid==0.
- Reset mid-burst: outputs clear immediately (async); remaining words lost; FIFO record already consumed is not re-read.

## Configuration
- SER_ONEHOT_CHECK_EN defined: ch_sel must be one-hot; zero or multi-hot records dropped with sel_err.
- Undefined: any nonzero ch_sel accepted; multi-hot broadcasts the same words to all selected channels (ch_valid = ch_sel); only ch_sel==0 dropped. len check identical in both builds.

## Test plan
- Single record len=1, ch_sel=8'h04, payload top word 16'hA5A5, ready high -> ch_valid=8'h04 one cycle with dout=16'hA5A5 at N+3, frame_done next cycle.
- len=8, ch_sel=8'h80, words 16'h0001..16'h0008, ready high -> eight consecutive cycles dout 0001..0008 on ch_valid=8'h80, one fifo_r_enable pulse only.
- len=3, ch_sel=8'h01, dout_ready low for 5 cycles mid-word 2 -> dout held at word 2, ch_valid held; total words transferred exactly 3.
- len=0 and len=9 records -> sel_err pulse each, ch_valid never asserted, next record processed normally.
- ch_sel=8'h03, len=2 -> with SER_ONEHOT_CHECK_EN: sel_err, no output; without: two words on ch_valid=8'h03.
- rst_n low during word 4 of len=8 burst -> all outputs 0 same cycle; after release, serializer idles until fifo_empty low, then starts next record cleanly.
